fir_tdm_mac: RTL and testbench
==============================

# fir_tdm_mac

Multi-channel, time-multiplexed FIR filter. It replaces the fully parallel single-channel filter with one shared signed multiply-accumulate unit that is stepped across every tap of every channel after each sample strobe. Output rounding, saturation, a valid strobe and an overrun flag are added. It sits between the sample-rate strobe generator and downstream audio-rate consumers, running on the system clock.

## Interface
- N, 32: signed sample width per channel.
- DELAYS, 3: number of z^-1 stages; taps = DELAYS+1.
- CHANNELS, 2: independent channels sharing the coefficient set.
- COEF_W, 32: signed coefficient width.
- FRAC, 0: result right-shift (fractional bits of coefficients); 0 to COEF_W-1.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  accept enable; gates sample acceptance only.
- x_valid  in  1  single-cycle sample strobe for all channels.
- x_in  in  CHANNELS*N  two's-complement samples; channel c at bits [c*N +: N].
- b  in  (DELAYS+1)*COEF_W  two's-complement coefficients, last-delay coefficient in the MSBs, b0 at [COEF_W-1:0]; must be stable while busy.
- y_out  out  CHANNELS*N  filtered samples, same packing as x_in; registered.
- y_valid  out  1  one-cycle pulse when y_out updates.
- busy  out  1  high while a sample set is being processed.
- overrun  out  1  sticky: x_valid arrived while busy.

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE: on x_valid && ena, shift every channel's delay line (x_in into tap 0), clear the accumulator, set channel=0 and tap=0, go to MAC. Otherwise hold.
- MAC: each cycle, acc += x[channel][tap] * b[tap], signed, full precision.
  - Accumulator width: N+COEF_W+clog2(DELAYS+1); no internal overflow.
  - On the last tap, the rounded and saturated result goes to channel's staging register, acc clears, and tap wraps to 0 with channel+1.
  - After the last tap of channel CHANNELS-1, go to OUT.
- OUT: copy all staging registers to y_out together, pulse y_valid, go to IDLE.
- Result arithmetic:
  - If FRAC>0, add 2^(FRAC-1) to acc, then arithmetic shift right by FRAC (round half toward +inf).
  - Clamp to [-2^(N-1), 2^(N-1)-1].
- x_valid while busy: sample discarded, delay lines untouched, overrun set; cleared only by rst.
- x_valid with ena low in IDLE: ignored, overrun unaffected.
- ena deassertion during MAC/OUT does not stop the computation in progress.
- Reset (any time, including mid-computation):
  - Delay lines, accumulator, staging registers and y_out all go to 0.
  - y_valid=0, busy=0, overrun=0, FSM to IDLE.
  - An aborted computation never produces y_valid.

## Timing
- Let M = CHANNELS*(DELAYS+1). Defaults give M=8.
- Edge t: sample accepted, busy rises.
- Edges t+1..t+M: one MAC per edge.
- Edge t+M+1: y_out and y_valid update, busy falls, FSM in IDLE.
- Latency from strobe to y_valid is M+1 cycles.
- The earliest next acceptance is edge t+M+2, giving a minimum strobe spacing of M+2 cycles.
- y_out holds its value until the next OUT.
- Output at sample n uses x[n..n-DELAYS] with x[n] = the sample just accepted.

## Test plan
- Impulse: defaults, b={193,376,376,193}, ch0 strobes 1000 then five strobes of 0 -> ch0 y_out 193000, 376000, 376000, 193000, 0, 0; ch1 stays 0; each y_valid exactly 9 cycles after its strobe.
- Channel independence: same b, ch0=1000 and ch1=-2 in the same strobe, then zeros -> ch1 gives -386, -752, -752, -386, 0 while ch0 matches the impulse case.
- Rounding: FRAC=10, all b=512, x=3 for one strobe -> ch0 y_out=2; repeat from reset with x=-3 -> y_out=-1.
- Saturation: FRAC=0, b all 1, ch0 held at 2147483647 for four strobes -> y_out 2147483647 (clamped from the 2nd strobe on); with x=-2147483648 -> -2147483648.
- Overrun: strobe, then a second strobe 3 cycles later carrying x=5000 -> second strobe ignored, overrun=1 and stays 1, output sequence identical to a run without the second strobe.
- Reset mid-op: assert rst 4 cycles after a strobe of 1000 -> y_out=0, busy=0, no y_valid; the next strobe after release yields 193000.

Source files
------------

// File: rtl/fir_tdm_mac.sv
// Multi-channel FIR filter that time-shares one signed MAC across every tap of every channel.
// Results are rounded, saturated and released for all channels together with a valid pulse.
module fir_tdm_mac #(
    parameter int unsigned N        = 32,
    parameter int unsigned DELAYS   = 3,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned COEF_W   = 32,
    parameter int unsigned FRAC     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         x_valid,
    input  logic [CHANNELS*N-1:0]        x_in,
    input  logic [(DELAYS+1)*COEF_W-1:0] b,
    output logic [CHANNELS*N-1:0]        y_out,
    output logic                         y_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned Taps  = DELAYS + 1;
    localparam int unsigned PrW   = N + COEF_W;
    localparam int unsigned AccW  = N + COEF_W + $clog2(Taps);
    localparam int unsigned TapW  = (Taps > 1) ? $clog2(Taps) : 1;
    localparam int unsigned ChW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned RndSh = (FRAC > 0) ? FRAC - 1 : 0;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    localparam logic signed [AccW:0] Half = (FRAC > 0) ? ((AccW+1)'(1) << RndSh) : '0;
    localparam logic signed [AccW:0] MaxV = (AccW+1)'({1'b0, {(N-1){1'b1}}});
    localparam logic signed [AccW:0] MinV = ~MaxV;

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                              state_q;
    logic [CHANNELS-1:0][Taps-1:0][N-1:0] dline_q;
    logic [CHANNELS-1:0][N-1:0]          stage_q;
    logic [CHANNELS-1:0][N-1:0]          y_q;
    logic signed [AccW-1:0]              acc_q;
    logic [TapW-1:0]                     tap_q;
    logic [ChW-1:0]                      ch_q;

    logic [CHANNELS-1:0][N-1:0]          x_ch;
    logic [Taps-1:0][COEF_W-1:0]         coef;
    logic signed [PrW-1:0]               prod;
    logic signed [AccW-1:0]              acc_sum;
    logic [N-1:0]                        res;
    logic                                last_tap;
    logic                                last_ch;

    assign x_ch  = x_in;
    assign coef  = b;
    assign y_out = y_q;

    function automatic logic [N-1:0] round_sat(input logic signed [AccW-1:0] a);
        logic signed [AccW:0] r;
        r = (AccW+1)'(a);
        r = (r + Half) >>> FRAC;
        if (r > MaxV) begin
            return MaxV[N-1:0];
        end else if (r < MinV) begin
            return MinV[N-1:0];
        end
        return r[N-1:0];
    endfunction

    always_comb begin
        prod     = $signed(dline_q[ch_q][tap_q]) * $signed(coef[tap_q]);
        acc_sum  = acc_q + AccW'(prod);
        res      = round_sat(acc_sum);
        last_tap = (tap_q == TapW'(Taps - 1));
        last_ch  = (ch_q == ChW'(CHANNELS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dline_q <= '0;
            stage_q <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            tap_q   <= '0;
            ch_q    <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            // Any strobe outside IDLE is dropped; the flag is sticky until reset.
            if (x_valid && state_q != StIdle) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (x_valid && ena) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            for (int k = Taps - 1; k > 0; k--) begin
                                dline_q[c][k] <= dline_q[c][k-1];
                            end
                            dline_q[c][0] <= x_ch[c];
                        end
                        acc_q   <= '0;
                        tap_q   <= '0;
                        ch_q    <= '0;
                        busy    <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (last_tap) begin
                        stage_q[ch_q] <= res;
                        acc_q         <= '0;
                        tap_q         <= '0;
                        if (last_ch) begin
                            state_q <= StOut;
                        end else begin
                            ch_q <= ch_q + ChW'(1);
                        end
                    end else begin
                        acc_q <= acc_sum;
                        tap_q <= tap_q + TapW'(1);
                    end
                end
                StOut: begin
                    y_q     <= stage_q;
                    y_valid <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac: expected outputs are queued at each strobe and checked,
// with latency, when y_valid fires. A second instance with FRAC=10 covers rounding.
module tb_fir_tdm_mac;

    localparam int N    = 32;
    localparam int CH   = 2;
    localparam int TAPS = 4;
    localparam int CW   = 32;
    localparam int LAT  = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b1;
    logic              xv1 = 1'b0;
    logic              xv2 = 1'b0;
    logic [CH*N-1:0]   x_in = '0;
    logic [TAPS*CW-1:0] b1 = '0;
    logic [TAPS*CW-1:0] b2 = '0;
    logic [CH*N-1:0]   y1;
    logic [CH*N-1:0]   y2;
    logic              yv1, yv2, busy1, busy2, ov1, ov2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int y0;
        int y1;
        int due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_tdm_mac #(.N(N), .DELAYS(TAPS-1), .CHANNELS(CH), .COEF_W(CW), .FRAC(0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .x_valid(xv1), .x_in(x_in), .b(b1),
        .y_out(y1), .y_valid(yv1), .busy(busy1), .overrun(ov1)
    );

    fir_tdm_mac #(.N(N), .DELAYS(TAPS-1), .CHANNELS(CH), .COEF_W(CW), .FRAC(10)) dut_frac (
        .clk(clk), .rst(rst), .ena(ena), .x_valid(xv2), .x_in(x_in), .b(b2),
        .y_out(y2), .y_valid(yv2), .busy(busy2), .overrun(ov2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        xv1 = 1'b0;
        xv2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic strobe(input bit sel, input int x0, input int x1);
        x_in = {x1, x0};
        if (sel) xv2 = 1'b1;
        else     xv1 = 1'b1;
        @(negedge clk);
        xv1 = 1'b0;
        xv2 = 1'b0;
    endtask

    task automatic expect_out(input int y0, input int ych1);
        exp_t e;
        e.y0  = y0;
        e.y1  = ych1;
        e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic wait_out(input bit sel, input string tag);
        exp_t            e;
        bit              seen;
        logic [CH*N-1:0] y;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? yv2 : yv1) === 1'b1) seen = 1'b1;
        end
        chk({tag, "_valid_seen"}, int'(seen), 1);
        if (seen) begin
            chk({tag, "_sb_pending"}, int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                y = sel ? y2 : y1;
                chk({tag, "_ch0"}, int'(y[N-1:0]), e.y0);
                chk({tag, "_ch1"}, int'(y[2*N-1:N]), e.y1);
                chk({tag, "_latency"}, cyc, e.due);
                chk({tag, "_busy_low"}, int'(sel ? busy2 : busy1), 0);
            end
            @(negedge clk);
            chk({tag, "_valid_pulse"}, int'(sel ? yv2 : yv1), 0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
        end
    endtask

    initial begin
        int imp[5];
        int ch1v[5];
        int imin;
        bit any;
        imp  = '{376000, 376000, 193000, 0, 0};
        ch1v = '{-752, -752, -386, 0, 0};
        imin = -2147483647 - 1;
        b1 = {32'd193, 32'd376, 32'd376, 32'd193};
        b2 = {4{32'd512}};

        cycles(2);
        rst = 1'b0;
        cycles(1);
        chk("rst_y_out", int'(y1 != '0), 0);
        chk("rst_y_valid", int'(yv1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_overrun", int'(ov1), 0);

        // Impulse response on channel 0.
        strobe(0, 1000, 0);
        chk("imp_busy_rise", int'(busy1), 1);
        expect_out(193000, 0);
        wait_out(0, "imp0");
        for (int i = 0; i < 5; i++) begin
            strobe(0, 0, 0);
            expect_out(imp[i], 0);
            wait_out(0, $sformatf("imp%0d", i + 1));
        end

        // ena low in IDLE: strobe ignored, no overrun.
        ena = 1'b0;
        strobe(0, 7, 7);
        cycles(2);
        chk("ena_low_busy", int'(busy1), 0);
        chk("ena_low_overrun", int'(ov1), 0);
        ena = 1'b1;

        // Channel independence.
        do_reset();
        strobe(0, 1000, -2);
        expect_out(193000, -386);
        wait_out(0, "indep0");
        for (int i = 0; i < 5; i++) begin
            strobe(0, 0, 0);
            expect_out(imp[i], ch1v[i]);
            wait_out(0, $sformatf("indep%0d", i + 1));
        end

        // Rounding with FRAC=10.
        do_reset();
        strobe(1, 3, 0);
        expect_out(2, 0);
        wait_out(1, "round_pos");
        do_reset();
        strobe(1, -3, 0);
        expect_out(-1, 0);
        wait_out(1, "round_neg");

        // Saturation at both rails.
        do_reset();
        b1 = {4{32'd1}};
        for (int i = 0; i < 4; i++) begin
            strobe(0, 2147483647, 0);
            expect_out(2147483647, 0);
            wait_out(0, $sformatf("sat_pos%0d", i));
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            strobe(0, imin, 0);
            expect_out(imin, 0);
            wait_out(0, $sformatf("sat_neg%0d", i));
        end

        // Overrun: second strobe mid-computation is dropped.
        do_reset();
        b1 = {32'd193, 32'd376, 32'd376, 32'd193};
        strobe(0, 1000, 0);
        expect_out(193000, 0);
        cycles(2);
        strobe(0, 5000, 0);
        chk("ovr_set", int'(ov1), 1);
        wait_out(0, "ovr0");
        strobe(0, 0, 0);
        expect_out(376000, 0);
        wait_out(0, "ovr1");
        chk("ovr_sticky", int'(ov1), 1);

        // Reset mid-computation aborts without y_valid.
        do_reset();
        chk("ovr_cleared", int'(ov1), 0);
        strobe(0, 1000, 0);
        cycles(3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_y_out", int'(y1 != '0), 0);
        rst = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (yv1 !== 1'b0) any = 1'b1;
        end
        chk("abort_no_valid", int'(any), 0);
        // ena dropped mid-computation must not stop it.
        strobe(0, 1000, 0);
        ena = 1'b0;
        expect_out(193000, 0);
        wait_out(0, "after_abort");
        ena = 1'b1;

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
